// File: rtl/spec_ras_if.sv
// Front-end interface of the speculative return-address stack: predictor push/pop,
// dispatch checkpoints, mispredict flush and the top-of-stack / pulse outputs.
interface spec_ras_if #(
    parameter int AW = 32,
    parameter int IW = 4
) ();
    logic          push_en;
    logic [AW-1:0] push_addr;
    logic          pop_en;
    logic          cp_en;
    logic [IW-1:0] cp_id;
    logic          flush_en;
    logic [IW-1:0] flush_id;
    logic          tos_valid;
    logic [AW-1:0] tos_addr;
    logic          overflow;
    logic          underflow;

    modport master (
        output push_en, push_addr, pop_en, cp_en, cp_id, flush_en, flush_id,
        input  tos_valid, tos_addr, overflow, underflow
    );

    modport slave (
        input  push_en, push_addr, pop_en, cp_en, cp_id, flush_en, flush_id,
        output tos_valid, tos_addr, overflow, underflow
    );
endinterface

// File: rtl/spec_ras.sv
// Speculative return-address stack with per-ROB-id checkpoints and flush recovery.
// Define RAS_TOS_REPAIR_EN to also checkpoint the TOS value and rewrite it on flush.
module spec_ras #(
    parameter int DEPTH      = 8,
    parameter int CP_ENTRIES = 16,
    parameter int AW         = 32
) (
    input  logic        clk,
    input  logic        rst,
    spec_ras_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};

    logic [AW-1:0] entry_r    [DEPTH];
    logic [PW-1:0] ptr_r;
    logic [CW-1:0] count_r;
    logic          overflow_r;
    logic          underflow_r;

    logic [PW-1:0] cp_ptr_r   [CP_ENTRIES];
    logic [CW-1:0] cp_count_r [CP_ENTRIES];
`ifdef RAS_TOS_REPAIR_EN
    logic [AW-1:0] cp_tos_r   [CP_ENTRIES];
    logic [AW-1:0] restore_tos_s;
    logic [AW-1:0] cp_tos_s;
`endif

    logic [PW-1:0] tos_idx_s;
    logic [AW-1:0] tos_s;
    logic [PW-1:0] restore_ptr_s;
    logic [CW-1:0] restore_count_s;
    logic [PW-1:0] cp_ptr_s;
    logic [CW-1:0] cp_count_s;
    logic [PW-1:0] ptr_s;
    logic [CW-1:0] count_s;
    logic          wr_en_s;
    logic [PW-1:0] wr_idx_s;
    logic [AW-1:0] wr_data_s;
    logic          overflow_s;
    logic          underflow_s;

    assign tos_idx_s       = ptr_r - PTR_ONE;
    assign restore_ptr_s   = cp_ptr_r[bus.flush_id];
    assign restore_count_s = cp_count_r[bus.flush_id];
`ifdef RAS_TOS_REPAIR_EN
    assign restore_tos_s   = cp_tos_r[bus.flush_id];
`endif

    // Top-of-stack read straight from current state; an empty stack reads as zero
    always_comb begin
        tos_s = ADDR_ZERO;
        if (count_r != CNT_ZERO) begin
            tos_s = entry_r[tos_idx_s];
        end else begin
            tos_s = ADDR_ZERO;
        end
    end

    assign bus.tos_valid = (count_r != CNT_ZERO);
    assign bus.tos_addr  = tos_s;
    assign bus.overflow  = overflow_r;
    assign bus.underflow = underflow_r;

    // Checkpoint payload: a slot saved during a flush to itself takes the restored state
    always_comb begin
        cp_ptr_s   = ptr_r;
        cp_count_s = count_r;
`ifdef RAS_TOS_REPAIR_EN
        cp_tos_s   = tos_s;
`endif
        if (bus.flush_en && (bus.cp_id == bus.flush_id)) begin
            cp_ptr_s   = restore_ptr_s;
            cp_count_s = restore_count_s;
`ifdef RAS_TOS_REPAIR_EN
            cp_tos_s   = restore_tos_s;
`endif
        end else begin
            cp_ptr_s   = ptr_r;
            cp_count_s = count_r;
`ifdef RAS_TOS_REPAIR_EN
            cp_tos_s   = tos_s;
`endif
        end
    end

    // Next pointer/count, entry write port and pulse requests; flush overrides push/pop
    always_comb begin
        ptr_s       = ptr_r;
        count_s     = count_r;
        wr_en_s     = 1'b0;
        wr_idx_s    = ptr_r;
        wr_data_s   = bus.push_addr;
        overflow_s  = 1'b0;
        underflow_s = 1'b0;
        if (bus.flush_en) begin
            ptr_s   = restore_ptr_s;
            count_s = restore_count_s;
`ifdef RAS_TOS_REPAIR_EN
            if (restore_count_s != CNT_ZERO) begin
                wr_en_s   = 1'b1;
                wr_idx_s  = restore_ptr_s - PTR_ONE;
                wr_data_s = restore_tos_s;
            end else begin
                wr_en_s   = 1'b0;
            end
`endif
        end else if (bus.push_en && bus.pop_en && (count_r != CNT_ZERO)) begin
            // Return followed by call: replace the top entry in place
            wr_en_s  = 1'b1;
            wr_idx_s = tos_idx_s;
        end else if (bus.push_en) begin
            wr_en_s  = 1'b1;
            wr_idx_s = ptr_r;
            ptr_s    = ptr_r + PTR_ONE;
            if (count_r == CNT_FULL) begin
                count_s    = count_r;
                overflow_s = 1'b1;
            end else begin
                count_s    = count_r + CNT_ONE;
                overflow_s = 1'b0;
            end
        end else if (bus.pop_en) begin
            if (count_r != CNT_ZERO) begin
                ptr_s   = ptr_r - PTR_ONE;
                count_s = count_r - CNT_ONE;
            end else begin
                underflow_s = 1'b1;
            end
        end else begin
            ptr_s   = ptr_r;
            count_s = count_r;
        end
    end

    // Pointer, occupancy and registered overflow/underflow pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_r       <= PTR_ZERO;
            count_r     <= CNT_ZERO;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            ptr_r       <= ptr_s;
            count_r     <= count_s;
            overflow_r  <= overflow_s;
            underflow_r <= underflow_s;
        end
    end

    // Stack storage; entries persist across flushes unless written
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_r[i] <= ADDR_ZERO;
            end
        end else if (wr_en_s) begin
            entry_r[wr_idx_s] <= wr_data_s;
        end
    end

    // Checkpoint slots indexed by ROB id
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CP_ENTRIES; i++) begin
                cp_ptr_r[i]   <= PTR_ZERO;
                cp_count_r[i] <= CNT_ZERO;
`ifdef RAS_TOS_REPAIR_EN
                cp_tos_r[i]   <= ADDR_ZERO;
`endif
            end
        end else if (bus.cp_en) begin
            cp_ptr_r[bus.cp_id]   <= cp_ptr_s;
            cp_count_r[bus.cp_id] <= cp_count_s;
`ifdef RAS_TOS_REPAIR_EN
            cp_tos_r[bus.cp_id]   <= cp_tos_s;
`endif
        end
    end
endmodule
